hop_grant_lock: RTL and testbench

Registered grant controller sitting directly downstream of the hop-count arbiter in each switch output port. It resolves ties reported by the hop-count arbiter with a round-robin pointer and registers the winning input. It then holds that grant for the whole wormhole packet, popping flits from the granted input buffer until the tail flit is accepted downstream. Its outputs drive the crossbar select and the input-buffer read enables.

---
 rtl/hop_grant_lock.sv | 105 ++++++++++
 tb/tb_hop_grant_lock.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hop_grant_lock.sv
// Output-port grant lock: registers the hop-count arbiter's winner and holds it for a whole
// wormhole packet. Optional feature macro HOP_GRANT_RR_TIEBREAK_EN (round-robin tie-break).
module hop_grant_lock #(
  parameter int unsigned IN_N  = 5,
  parameter int unsigned SEL_W = $clog2(IN_N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IN_N-1:0]  cand_i,
  input  logic [SEL_W-1:0] arb_res_i,
  input  logic             not_conclusive_i,
  input  logic [IN_N-1:0]  vld_i,
  input  logic [IN_N-1:0]  tail_i,
  input  logic             out_rdy_i,
  output logic [IN_N-1:0]  grant_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             grant_vld_o,
  output logic             out_vld_o,
  output logic [IN_N-1:0]  rd_en_o
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           state_q;
  logic [IN_N-1:0]  grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] tie_win;
  logic [SEL_W-1:0] win_idx;
  logic             xfer;

`ifdef HOP_GRANT_RR_TIEBREAK_EN
  logic [SEL_W-1:0] rr_ptr_q;

  // Cyclic search starting just after the last tie winner.
  always_comb begin
    int unsigned idx;
    logic        found;
    tie_win = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= IN_N; k++) begin
      idx = (32'(rr_ptr_q) + k) % IN_N;
      if (!found && cand_i[idx[SEL_W-1:0]]) begin
        found   = 1'b1;
        tie_win = idx[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= SEL_W'(IN_N - 1);
    end else if (state_q == StIdle && (|cand_i) && not_conclusive_i) begin
      rr_ptr_q <= tie_win;
    end
  end
`else
  // Fixed priority: lowest set index wins.
  always_comb begin
    tie_win = '0;
    for (int i = int'(IN_N) - 1; i >= 0; i--) begin
      if (cand_i[i]) begin
        tie_win = SEL_W'(i);
      end
    end
  end
`endif

  assign win_idx = not_conclusive_i ? tie_win : arb_res_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|cand_i) begin
            state_q <= StLocked;
            sel_q   <= win_idx;
            grant_q <= IN_N'(1) << win_idx;
          end
        end
        StLocked: begin
          // Inputs from the arbiter are ignored here so packets never interleave.
          if (xfer && tail_i[sel_q]) begin
            state_q <= StIdle;
            grant_q <= '0;
            sel_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign sel_o       = sel_q;
  assign grant_vld_o = (state_q == StLocked);
  assign out_vld_o   = grant_vld_o & vld_i[sel_q];
  assign xfer        = out_vld_o & out_rdy_i;
  assign rd_en_o     = grant_q & {IN_N{xfer}};

endmodule

// File: tb/tb_hop_grant_lock.sv
// Self-checking bench for hop_grant_lock: directed vector table, tie/reset sequences and a
// randomized run against a packet-level model. Honours HOP_GRANT_RR_TIEBREAK_EN.
module tb_hop_grant_lock;
  localparam int N = 5;

  logic       clk, rst_n;
  logic [4:0] cand, vld, tail;
  logic [2:0] arb;
  logic       nc, rdy;
  logic [4:0] grant, rd_en;
  logic [2:0] sel;
  logic       grant_vld, out_vld;

  int checks = 0;
  int errors = 0;

  hop_grant_lock #(.IN_N(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cand_i(cand), .arb_res_i(arb), .not_conclusive_i(nc),
    .vld_i(vld), .tail_i(tail), .out_rdy_i(rdy), .grant_o(grant), .sel_o(sel),
    .grant_vld_o(grant_vld), .out_vld_o(out_vld), .rd_en_o(rd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] c; logic [2:0] a; logic n; logic [4:0] v; logic [4:0] t; logic r;
    logic [4:0] g; logic [2:0] s; logic gv; logic ov; logic [4:0] rd;
  } vec_t;

  vec_t tbl[21];

  // Packet-level reference state.
  bit m_locked;
  int m_gidx;
  int m_rr;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] g, input logic [2:0] s,
                         input logic gv, input logic ov, input logic [4:0] rd);
    chk({tag, ".grant"}, 8'(grant), 8'(g));
    chk({tag, ".sel"}, 8'(sel), 8'(s));
    chk({tag, ".grant_vld"}, 8'(grant_vld), 8'(gv));
    chk({tag, ".out_vld"}, 8'(out_vld), 8'(ov));
    chk({tag, ".rd_en"}, 8'(rd_en), 8'(rd));
  endtask

  task automatic apply(input logic [4:0] c, input logic [2:0] a, input logic n,
                       input logic [4:0] v, input logic [4:0] t, input logic r);
    @(negedge clk);
    cand = c; arb = a; nc = n; vld = v; tail = t; rdy = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cand = '0; arb = '0; nc = 1'b0; vld = 5'b11111; tail = '0; rdy = 1'b1;
    #1;
    chk_all("reset", 5'b0, 3'd0, 1'b0, 1'b0, 5'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_locked = 1'b0; m_gidx = 0; m_rr = N - 1;
  endtask

  function automatic int tie_winner(input logic [4:0] c, input int rr);
`ifdef HOP_GRANT_RR_TIEBREAK_EN
    for (int k = 1; k <= N; k++) if (c[(rr + k) % N]) return (rr + k) % N;
`else
    for (int i = 0; i < N; i++) if (c[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_step(input logic [4:0] c, input logic [2:0] a, input logic n,
                            input logic [4:0] v, input logic [4:0] t, input logic r);
    if (!m_locked) begin
      if (c != 0) begin
        m_locked = 1'b1;
        if (!n) m_gidx = int'(a);
        else begin
          m_gidx = tie_winner(c, m_rr);
          m_rr   = m_gidx;
        end
      end
    end else if (v[m_gidx] && r && t[m_gidx]) begin
      m_locked = 1'b0;
    end
  endtask

  initial begin
    int         w;
    int         exp_t[3];
    logic [4:0] c, v, t, eg, erd;
    logic [2:0] a;
    logic       n, r, eov;

    // cand, arb, nc, vld, tail, rdy | grant, sel, gvld, ovld, rd_en
    tbl[0]  = '{5'b00100, 3'd2, 1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{5'b00000, 3'd0, 1'b0, 5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100};
    tbl[2]  = '{5'b00000, 3'd0, 1'b0, 5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100};
    tbl[3]  = '{5'b00000, 3'd0, 1'b0, 5'b00100, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100};
    tbl[4]  = '{5'b00000, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[5]  = '{5'b00001, 3'd0, 1'b0, 5'b00001, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[6]  = '{5'b00000, 3'd0, 1'b0, 5'b00001, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00000};
    tbl[7]  = '{5'b00000, 3'd0, 1'b0, 5'b00001, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00000};
    tbl[8]  = '{5'b00000, 3'd0, 1'b0, 5'b00001, 5'b00000, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001};
    tbl[9]  = '{5'b00000, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0, 5'b00000};
    tbl[10] = '{5'b00000, 3'd0, 1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001};
    tbl[11] = '{5'b00000, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[12] = '{5'b10000, 3'd4, 1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[13] = '{5'b00001, 3'd0, 1'b0, 5'b10000, 5'b00000, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000};
    tbl[14] = '{5'b00001, 3'd0, 1'b1, 5'b10001, 5'b00000, 1'b0, 5'b10000, 3'd4, 1'b1, 1'b1, 5'b00000};
    tbl[15] = '{5'b00001, 3'd0, 1'b0, 5'b10001, 5'b10000, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000};
    tbl[16] = '{5'b00001, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[17] = '{5'b00000, 3'd0, 1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001};
    tbl[18] = '{5'b00000, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[19] = '{5'b00000, 3'd0, 1'b1, 5'b11111, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};
    tbl[20] = '{5'b00000, 3'd0, 1'b1, 5'b11111, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000};

    rst_n = 1'b1;
    cand = '0; arb = '0; nc = 1'b0; vld = '0; tail = '0; rdy = 1'b0;
    do_reset();

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].c, tbl[i].a, tbl[i].n, tbl[i].v, tbl[i].t, tbl[i].r);
      chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].gv, tbl[i].ov, tbl[i].rd);
      @(posedge clk);
    end

    // Tie rotation: three single-flit packets from candidates {1,3}.
`ifdef HOP_GRANT_RR_TIEBREAK_EN
    exp_t = '{1, 3, 1};
`else
    exp_t = '{1, 1, 1};
`endif
    do_reset();
    for (int p = 0; p < 3; p++) begin
      w = exp_t[p];
      apply(5'b01010, 3'd0, 1'b1, 5'b0, 5'b0, 1'b1);
      @(posedge clk);
      eg = 5'(1 << w);
      apply(5'b0, 3'd0, 1'b0, eg, eg, 1'b1);
      chk_all($sformatf("tie%0d", p), eg, 3'(w), 1'b1, 1'b1, eg);
      @(posedge clk);
    end

    // Reset asserted mid-packet, then ties on all inputs.
    do_reset();
    apply(5'b00100, 3'd2, 1'b0, 5'b0, 5'b0, 1'b1);
    @(posedge clk);
    apply(5'b0, 3'd0, 1'b0, 5'b00100, 5'b0, 1'b1);
    chk("midrst.pre_rd", 8'(rd_en), 8'b00100);
    #1 rst_n = 1'b0;
    #1;
    chk_all("midrst", 5'b0, 3'd0, 1'b0, 1'b0, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cand = 5'b11111; nc = 1'b1; vld = '0;
    #1;
    chk("midrst.idle", 8'(grant_vld), 8'd0);
    @(posedge clk);
    apply(5'b0, 3'd0, 1'b0, 5'b00001, 5'b00001, 1'b1);
    chk("midrst.tie1", 8'(grant), 8'b00001);
    @(posedge clk);
    apply(5'b11111, 3'd0, 1'b1, 5'b0, 5'b0, 1'b1);
    @(posedge clk);
`ifdef HOP_GRANT_RR_TIEBREAK_EN
    eg = 5'b00010;
`else
    eg = 5'b00001;
`endif
    apply(5'b0, 3'd0, 1'b0, eg, eg, 1'b1);
    chk("midrst.tie2", 8'(grant), 8'(eg));
    @(posedge clk);

    // Randomized traffic against the packet model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom);
      a = 3'($urandom_range(0, N - 1));
      n = 1'($urandom);
      v = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'b11111;
      t = 5'($urandom) & 5'($urandom);
      r = ($urandom_range(0, 3) != 0);
      eg  = m_locked ? 5'(1 << m_gidx) : 5'b0;
      eov = m_locked && v[m_gidx];
      erd = (eov && r) ? eg : 5'b0;
      apply(c, a, n, v, t, r);
      chk_all("rand", eg, m_locked ? 3'(m_gidx) : 3'd0, m_locked, eov, erd);
      @(posedge clk);
      model_step(c, a, n, v, t, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
